// File: rtl/uart_tx_core.sv
// Autonomous 8N1 UART beacon: repeatedly transmits "Hello\r\n" followed by
// GAP_BITS idle bit-times, forever.
module uart_tx_core #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned GAP_BITS     = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic out
);

  localparam int unsigned DIV_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned GAP_W     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LAST_BYTE = 6;
  localparam int unsigned LAST_BIT  = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [IDX_W-1:0]   r_byte_idx;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [DIV_W-1:0]   r_div;
  logic               r_out;

  state_t             w_state_nxt;
  logic [GAP_W-1:0]   w_gap_cnt_nxt;
  logic [IDX_W-1:0]   w_byte_idx_nxt;
  logic [IDX_W-1:0]   w_bit_idx_nxt;
  logic [DIV_W-1:0]   w_div_nxt;
  logic               w_out_nxt;
  logic               w_tick;
  logic [7:0]         w_byte;
  logic [IDX_W-1:0]   w_bit_inc;

  // Message ROM; index 7 is never reached because the byte index wraps at 6.
  function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    rom_byte = 8'h48;
      3'd1:    rom_byte = 8'h65;
      3'd2:    rom_byte = 8'h6C;
      3'd3:    rom_byte = 8'h6C;
      3'd4:    rom_byte = 8'h6F;
      3'd5:    rom_byte = 8'h0D;
      3'd6:    rom_byte = 8'h0A;
      default: rom_byte = 8'hFF;
    endcase
  endfunction

  assign w_byte    = rom_byte(r_byte_idx);
  assign w_tick    = (r_div == DIV_W'(CLKS_PER_BIT - 1));
  assign w_bit_inc = IDX_W'(r_bit_idx + IDX_W'(1));
  assign out       = r_out;

  // Next-state logic; r_out always shows the bit belonging to r_state.
  always_comb begin
    w_state_nxt    = r_state;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_byte_idx_nxt = r_byte_idx;
    w_bit_idx_nxt  = r_bit_idx;
    w_out_nxt      = r_out;
    w_div_nxt      = w_tick ? '0 : DIV_W'(r_div + DIV_W'(1));

    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_gap_cnt == GAP_W'(GAP_BITS - 1)) begin
            w_state_nxt   = S_START;
            w_gap_cnt_nxt = '0;
            w_out_nxt     = 1'b0;
          end else begin
            w_gap_cnt_nxt = GAP_W'(r_gap_cnt + GAP_W'(1));
          end
        end
        S_START: begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
          w_out_nxt     = w_byte[0];
        end
        S_DATA: begin
          if (r_bit_idx == IDX_W'(LAST_BIT)) begin
            w_state_nxt   = S_STOP;
            w_bit_idx_nxt = '0;
            w_out_nxt     = 1'b1;
          end else begin
            w_bit_idx_nxt = w_bit_inc;
            w_out_nxt     = w_byte[w_bit_inc];
          end
        end
        S_STOP: begin
          if (r_byte_idx < IDX_W'(LAST_BYTE)) begin
            w_state_nxt    = S_START;
            w_byte_idx_nxt = IDX_W'(r_byte_idx + IDX_W'(1));
            w_out_nxt      = 1'b0;
          end else begin
            w_state_nxt    = S_IDLE;
            w_byte_idx_nxt = '0;
            w_gap_cnt_nxt  = '0;
            w_out_nxt      = 1'b1;
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_gap_cnt_nxt  = '0;
          w_byte_idx_nxt = '0;
          w_bit_idx_nxt  = '0;
          w_out_nxt      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_div      <= '0;
      r_out      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_div      <= w_div_nxt;
      r_out      <= w_out_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: two instances (1 and 16 clocks/bit),
// per-edge line model plus a reference UART receiver, random reset pulses.
module tb_uart_tx_core;

  localparam int unsigned CPB_A = 1;
  localparam int unsigned GAP_A = 4;
  localparam int unsigned CPB_B = 16;
  localparam int unsigned GAP_B = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic out_a;
  logic out_b;

  uart_tx_core #(.CLKS_PER_BIT(CPB_A), .GAP_BITS(GAP_A)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (out_a)
  );

  uart_tx_core #(.CLKS_PER_BIT(CPB_B), .GAP_BITS(GAP_B)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (out_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  byte unsigned msg [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

  bit            exp_a [$];
  bit            exp_b [$];
  byte unsigned  rxq_a [$];
  byte unsigned  rxq_b [$];
  int unsigned   edge_cnt = 0;

  logic          rx_busy [2];
  int unsigned   rx_cnt  [2];
  logic [7:0]    rx_sh   [2];
  int unsigned   rx_seg  [2];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // Ideal line sequence: gap ones, then 7 frames of start/8 data LSB-first/stop.
  function automatic bit s_bit(input int unsigned idx, input int unsigned gap);
    int unsigned k, b, pos;
    byte unsigned v;
    if (idx < gap) return 1'b1;
    k   = idx - gap;
    b   = k / 10;
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    v = msg[b];
    return v[pos-1];
  endfunction

  function automatic bit exp_line(input int unsigned e, input int unsigned cpb,
                                  input int unsigned gap);
    return s_bit((e / cpb) % (70 + gap), gap);
  endfunction

  // Model: each rising edge yields one expected line value per instance.
  always @(posedge clk) begin
    if (!rst_n) edge_cnt = 0;
    else        edge_cnt++;
    exp_a.push_back(exp_line(edge_cnt, CPB_A, GAP_A));
    exp_b.push_back(exp_line(edge_cnt, CPB_B, GAP_B));
  end

  // Monitor and reference receiver, sampled on the falling edge.
  always @(negedge clk) begin
    logic        ln;
    int unsigned cpb;
    int unsigned k;
    byte unsigned want;
    if (exp_a.size() > 0) chk($sformatf("line_a e=%0d", edge_cnt), {7'd0, out_a}, {7'd0, exp_a.pop_front()});
    if (exp_b.size() > 0) chk($sformatf("line_b e=%0d", edge_cnt), {7'd0, out_b}, {7'd0, exp_b.pop_front()});
    for (int d = 0; d < 2; d++) begin
      ln  = (d == 0) ? out_a : out_b;
      cpb = (d == 0) ? CPB_A : CPB_B;
      if (!rst_n) begin
        rx_busy[d] = 1'b0;
      end else if (!rx_busy[d]) begin
        if (ln == 1'b0) begin
          rx_busy[d] = 1'b1;
          rx_cnt[d]  = 0;
        end
      end else begin
        rx_cnt[d]++;
        if (rx_cnt[d] >= cpb && ((rx_cnt[d] - cpb / 2) % cpb) == 0) begin
          k = (rx_cnt[d] - cpb / 2) / cpb;
          if (k <= 8) begin
            rx_sh[d][3'(k - 1)] = ln;
          end else begin
            rx_busy[d] = 1'b0;
            chk($sformatf("rx_stop dut=%0d", d), {7'd0, ln}, 8'd1);
            if ((d == 0 && rxq_a.size() == 0) || (d == 1 && rxq_b.size() == 0)) begin
              total++;
              bad++;
              $display("FAIL rx_extra dut=%0d got=%h want=none", d, rx_sh[d]);
            end else begin
              want = (d == 0) ? rxq_a.pop_front() : rxq_b.pop_front();
              chk($sformatf("rx_byte dut=%0d n=%0d", d, rx_seg[d]), rx_sh[d], want);
            end
            rx_seg[d]++;
          end
        end
      end
    end
  end

  // Release reset just after a falling edge and queue the bytes the receivers must see.
  task automatic release_rst();
    #1;
    rxq_a.delete();
    rxq_b.delete();
    repeat (20) foreach (msg[i]) rxq_a.push_back(msg[i]);
    repeat (3)  foreach (msg[i]) rxq_b.push_back(msg[i]);
    rx_seg[0] = 0;
    rx_seg[1] = 0;
    rst_n = 1'b1;
  endtask

  task automatic pulse_rst(input int unsigned hold);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_a", {7'd0, out_a}, 8'd1);
    chk("async_rst_b", {7'd0, out_b}, 8'd1);
    repeat (hold) @(negedge clk);
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rx_busy[0] = 1'b0;
    rx_busy[1] = 1'b0;
    rx_cnt[0]  = 0;
    rx_cnt[1]  = 0;
    rx_sh[0]   = '0;
    rx_sh[1]   = '0;
    rx_seg[0]  = 0;
    rx_seg[1]  = 0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_a", {7'd0, out_a}, 8'd1);
    chk("rst_out_b", {7'd0, out_b}, 8'd1);
    run(3);
    release_rst();

    // Long run: several full messages on the fast line, one on the slow line.
    run(1300);
    #1;
    total++;
    if (rx_seg[0] < 14) begin
      bad++;
      $display("FAIL rx_count_a got=%0d want>=14", rx_seg[0]);
    end
    total++;
    if (rx_seg[1] < 7) begin
      bad++;
      $display("FAIL rx_count_b got=%0d want>=7", rx_seg[1]);
    end
    pulse_rst(2);
    release_rst();

    // Reset during data bit 0 of byte 3 on the fast line (a low bit).
    run(35);
    #1;
    chk("pre_rst_a", {7'd0, out_a}, 8'd0);
    chk("pre_rst_b", {7'd0, out_b}, 8'd0);
    pulse_rst(3);
    release_rst();
    run(300);

    for (int it = 0; it < 6; it++) begin
      pulse_rst($urandom_range(1, 4));
      release_rst();
      run($urandom_range(20, 400));
    end

    pulse_rst(2);
    release_rst();
    run(400);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
